dpu_inst_queue: RTL and testbench

- Parametrised instruction/PC buffer between PFU and the DPU decoder.
- Generalises the single-entry decode input register to a DEPTH-entry circular queue.
- Adds ready/valid on both sides, central-control flush and stall, occupancy reporting and an almost-full indication.
- Output side feeds the DECODER; input side accepts pfu2dpu traffic.

---
 rtl/dpu_inst_queue.sv | 85 ++++++++
 tb/tb_dpu_inst_queue.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dpu_inst_queue.sv
// Circular instruction/PC queue between the prefetch unit and the DPU decoder.
// Registered storage, ready/valid on both sides, flush/stall from central control.
module dpu_inst_queue #(
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = 3,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [INST_WIDTH-1:0] in_inst_i,
  input  logic [PC_WIDTH-1:0]   in_pc_i,
  output logic                  in_ready_o,
  input  logic                  flush_i,
  input  logic                  stall_i,
  output logic                  out_valid_o,
  output logic [INST_WIDTH-1:0] out_inst_o,
  output logic [PC_WIDTH-1:0]   out_pc_o,
  input  logic                  out_ready_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  almost_full_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = INST_WIDTH + PC_WIDTH;

  logic [ENTRY_W-1:0]   mem_reg [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic [ENTRY_W-1:0]   head;
  logic                 not_empty;
  logic                 push;
  logic                 pop;

  assign not_empty     = (count_reg != '0);
  assign in_ready_o    = !rst_i && !flush_i && (count_reg < CNT_WIDTH'(DEPTH));
  assign out_valid_o   = not_empty && !stall_i && !flush_i;
  assign push          = in_valid_i && in_ready_o;
  assign pop           = out_valid_o && out_ready_i;
  assign count_o       = count_reg;
  assign almost_full_o = (count_reg >= CNT_WIDTH'(AFULL_LVL));

  // Outputs read zero when empty so the decoder never sees a stale entry.
  assign head       = mem_reg[rd_ptr_reg];
  assign out_inst_o = not_empty ? head[ENTRY_W-1:PC_WIDTH] : '0;
  assign out_pc_o   = not_empty ? head[PC_WIDTH-1:0] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          mem_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= {in_inst_i, in_pc_i};
        end
      end
    end
  endgenerate

  // Flush wins over everything; push/pop are already gated off during flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_dpu_inst_queue.sv
// Directed bench for dpu_inst_queue (DEPTH=4): fill/drain, wrap, stall, flush, async reset.
module tb_dpu_inst_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic [31:0] in_inst_i;
  logic [31:0] in_pc_i;
  logic        in_ready_o;
  logic        flush_i;
  logic        stall_i;
  logic        out_valid_o;
  logic [31:0] out_inst_o;
  logic [31:0] out_pc_o;
  logic        out_ready_i;
  logic [2:0]  count_o;
  logic        almost_full_o;

  int total = 0;
  int bad   = 0;

  dpu_inst_queue #(
    .INST_WIDTH(32), .PC_WIDTH(32), .DEPTH(4), .AFULL_LVL(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_inst_i(in_inst_i), .in_pc_i(in_pc_i),
    .in_ready_o(in_ready_o), .flush_i(flush_i), .stall_i(stall_i),
    .out_valid_o(out_valid_o), .out_inst_o(out_inst_o), .out_pc_o(out_pc_o),
    .out_ready_i(out_ready_i), .count_o(count_o), .almost_full_o(almost_full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [31:0] pc, input logic ordy,
                       input logic stl, input logic fl);
    @(negedge clk_i);
    in_valid_i  = v;
    in_inst_i   = 32'h0000_0013;
    in_pc_i     = pc;
    out_ready_i = ordy;
    stall_i     = stl;
    flush_i     = fl;
    #1;
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 0; in_inst_i = 0; in_pc_i = 0;
    flush_i = 0; stall_i = 0; out_ready_i = 0;
    #1;
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_count", count_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b0; #1;
    chk("idle_in_ready", in_ready_o, 1);
    chk("idle_out_valid", out_valid_o, 0);
    chk("idle_count", count_o, 0);
    chk("idle_inst", out_inst_o, 0);
    chk("idle_pc", out_pc_o, 0);

    // Fill with decoder not ready
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 0, 0, 0);
      chk("fill_count", count_o, 64'(i));
      chk("fill_in_ready", in_ready_o, 1);
      chk("fill_afull", almost_full_o, (i >= 3) ? 1 : 0);
    end
    drive(1, 32'h110, 0, 0, 0);
    chk("full_count", count_o, 4);
    chk("full_in_ready", in_ready_o, 0);
    chk("full_afull", almost_full_o, 1);
    chk("full_head_pc", out_pc_o, 32'h100);
    chk("full_head_inst", out_inst_o, 32'h13);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0);
      chk("drain_valid", out_valid_o, 1);
      chk("drain_pc", out_pc_o, 32'h100 + 32'(4 * i));
      chk("drain_count", count_o, 64'(4 - i));
    end
    drive(0, 0, 1, 0, 0);
    chk("empty_count", count_o, 0);
    chk("empty_valid", out_valid_o, 0);
    chk("empty_pc", out_pc_o, 0);

    // Simultaneous push/pop at count 2 across pointer wrap
    drive(1, 32'h300, 0, 0, 0);
    drive(1, 32'h304, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h308 + 32'(4 * k), 1, 0, 0);
      chk("pp_count", count_o, 2);
      chk("pp_pc", out_pc_o, 32'h300 + 32'(4 * k));
    end
    drive(0, 0, 1, 0, 0);
    chk("pp_tail0", out_pc_o, 32'h328);
    drive(0, 0, 1, 0, 0);
    chk("pp_tail1", out_pc_o, 32'h32C);
    drive(0, 0, 0, 0, 0);
    chk("pp_end_count", count_o, 0);

    // Stall with 2 entries while pushing
    drive(1, 32'h400, 0, 0, 0);
    drive(1, 32'h404, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h408 + 32'(4 * k), 1, 1, 0);
      chk("stall_valid", out_valid_o, 0);
      chk("stall_count", count_o, (k < 2) ? 64'(2 + k) : 64'd4);
      chk("stall_head", out_pc_o, 32'h400);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0);
      chk("unstall_pc", out_pc_o, 32'h400 + 32'(4 * i));
      chk("unstall_count", count_o, 64'(4 - i));
    end
    drive(0, 0, 0, 0, 0);
    chk("unstall_end", count_o, 0);

    // Flush at count 3 with push and pop both requested
    for (int i = 0; i < 3; i++) drive(1, 32'h500 + 32'(4 * i), 0, 0, 0);
    drive(1, 32'h50C, 1, 0, 1);
    chk("flush_in_ready", in_ready_o, 0);
    chk("flush_out_valid", out_valid_o, 0);
    chk("flush_count_before", count_o, 3);
    drive(1, 32'h200, 0, 0, 0);
    chk("post_flush_count", count_o, 0);
    chk("post_flush_valid", out_valid_o, 0);
    drive(0, 0, 1, 0, 0);
    chk("post_flush_first_pc", out_pc_o, 32'h200);
    chk("post_flush_one", count_o, 1);
    drive(0, 0, 0, 0, 0);
    chk("post_flush_empty", count_o, 0);

    // Asynchronous reset mid-cycle at count 3
    for (int i = 0; i < 3; i++) drive(1, 32'h600 + 32'(4 * i), 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("pre_rst_count", count_o, 3);
    #1 rst_i = 1'b1; #1;
    chk("arst_count", count_o, 0);
    chk("arst_valid", out_valid_o, 0);
    chk("arst_pc", out_pc_o, 0);
    chk("arst_afull", almost_full_o, 0);
    chk("arst_in_ready", in_ready_o, 0);
    @(negedge clk_i); rst_i = 1'b0; out_ready_i = 1; #1;
    chk("after_rst_count", count_o, 0);
    chk("after_rst_valid", out_valid_o, 0);
    chk("after_rst_in_ready", in_ready_o, 1);
    drive(0, 0, 1, 0, 0);
    chk("after_rst_no_stale", out_valid_o, 0);
    chk("after_rst_pc", out_pc_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
